// File: rtl/uart_frame_reporter.sv
// Periodic/triggered telemetry reporter: snapshots N_CH channels and sends
// HEADER, payload (channel 0 first, MSB byte first) and an 8-bit payload sum over 8N1 UART.
module uart_frame_reporter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned PERIOD   = 50_000_000,
  parameter int unsigned BAUD_DIV = 434,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic                   trig,
  input  logic                   period_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   dropped,
  output logic                   Rs232_Tx
);

  localparam int unsigned PW = N_CH * DATA_W;
  localparam int unsigned NB = 2 + PW / 8;
  localparam int unsigned IW = $clog2(NB);
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam int unsigned CW = $clog2(PERIOD);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
  localparam logic [IW-1:0] LAST_PL   = IW'(NB - 2);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] snap_q, snap_d;
  logic [IW-1:0] byte_q, byte_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [7:0]    csum_q, csum_d;
  logic [9:0]    sh_q, sh_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  logic tick, req, bit_end, byte_end;

  assign tick     = period_en && (cnt_q == CNT_LAST);
  assign req      = trig | tick;
  assign bit_end  = (baud_q == BAUD_LAST);
  assign byte_end = bit_end && (bit_q == 4'd9);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    csum_d  = csum_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    drop_d  = req && (state_q == SEND);
    cnt_d   = '0;
    if (period_en) cnt_d = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SEND;
          // Snapshot is stored in wire order so bytes can simply be shifted out of the top.
          for (int c = 0; c < N_CH; c++)
            snap_d[(N_CH-1-c)*DATA_W +: DATA_W] = ch_data[c*DATA_W +: DATA_W];
          csum_d = '0;
          byte_d = '0;
          bit_d  = '0;
          baud_d = '0;
          sh_d   = {1'b1, HEADER, 1'b0};
        end
      end
      SEND: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;
          sh_d   = {1'b1, sh_q[9:1]};
          if (byte_end) begin
            bit_d = '0;
            if (byte_q == LAST_IDX) begin
              state_d = IDLE;
              done_d  = 1'b1;
              sh_d    = '1;
            end else if (byte_q == LAST_PL) begin
              byte_d = byte_q + 1'b1;
              sh_d   = {1'b1, csum_q, 1'b0};
            end else begin
              byte_d = byte_q + 1'b1;
              sh_d   = {1'b1, snap_q[PW-1 -: 8], 1'b0};
              snap_d = snap_q << 8;
              csum_d = csum_q + snap_q[PW-1 -: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the snapshot register is reset too, as it is small.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      csum_q  <= '0;
      sh_q    <= '1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      csum_q  <= csum_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign busy       = (state_q == SEND);
  assign frame_done = done_q;
  assign dropped    = drop_q;
  assign Rs232_Tx   = sh_q[0];

endmodule

// File: tb/tb_uart_frame_reporter.sv
// Self-checking bench: cycle-accurate behavioural frame model, per-cycle output
// compare, an independent UART receiver and literal frame expectations.
module tb_uart_frame_reporter;

  localparam int DATA_W = 32;
  localparam int N_CH   = 2;
  localparam int PERIOD = 300;
  localparam int BD     = 4;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int PW  = N_CH * DATA_W;
  localparam int BPC = DATA_W / 8;
  localparam int NP  = PW / 8;
  localparam int NB  = NP + 2;
  localparam int L   = NB * 10 * BD;

  logic          Clk, Rst_n, trig, period_en;
  logic [PW-1:0] ch_data;
  logic          busy, frame_done, dropped, Rs232_Tx;

  uart_frame_reporter #(
    .DATA_W(DATA_W), .N_CH(N_CH), .PERIOD(PERIOD), .BAUD_DIV(BD), .HEADER(HDR)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ch_data(ch_data), .trig(trig), .period_en(period_en),
    .busy(busy), .frame_done(frame_done), .dropped(dropped), .Rs232_Tx(Rs232_Tx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a byte list plus the cycle offset since capture.
  bit         m_busy, m_done, m_drop, m_tick, m_req;
  int         m_pos, m_cnt;
  logic [7:0] m_bytes [NB];
  logic [7:0] m_sum;

  initial begin
    m_busy = 0; m_done = 0; m_drop = 0; m_pos = 0; m_cnt = 0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        m_busy = 0; m_done = 0; m_drop = 0; m_pos = 0; m_cnt = 0;
      end else begin
        m_tick = period_en && (m_cnt == PERIOD - 1);
        m_req  = trig || m_tick;
        m_cnt  = period_en ? (m_cnt + 1) % PERIOD : 0;
        m_drop = m_req && m_busy;
        m_done = 0;
        if (m_busy) begin
          m_pos++;
          if (m_pos == L) begin
            m_busy = 0;
            m_done = 1;
          end
        end else if (m_req) begin
          m_busy     = 1;
          m_pos      = 0;
          m_bytes[0] = HDR;
          m_sum      = 8'h00;
          for (int j = 0; j < NP; j++) begin
            m_bytes[1+j] = 8'(ch_data >> (DATA_W * (j / BPC) + 8 * (BPC - 1 - j % BPC)));
            m_sum += m_bytes[1+j];
          end
          m_bytes[NB-1] = m_sum;
        end
      end
    end
  end

  function automatic logic exp_tx();
    int bn, by, b;
    if (!m_busy) return 1'b1;
    bn = m_pos / BD;
    by = bn / 10;
    b  = bn % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_bytes[by][b-1];
  endfunction

  // Per-cycle compare plus monotonic pulse counters.
  int done_cnt = 0, drop_cnt = 0, busy_cyc = 0;

  initial forever begin
    @(negedge Clk);
    check("tx_line", Rs232_Tx, exp_tx());
    check("busy", busy, m_busy);
    check("frame_done", frame_done, m_done);
    check("dropped", dropped, m_drop);
    if (frame_done === 1'b1) done_cnt++;
    if (dropped === 1'b1) drop_cnt++;
    if (busy === 1'b1) busy_cyc++;
  end

  // Independent UART receiver sampling mid-bit.
  logic [7:0] rx_q [$];

  initial begin : rx
    logic [7:0] b;
    forever begin
      @(negedge Clk);
      if (Rst_n === 1'b1 && Rs232_Tx === 1'b0) begin
        repeat (BD / 2) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge Clk);
          b[i] = Rs232_Tx;
        end
        repeat (BD) @(negedge Clk);
        check("rx_stop_bit", Rs232_Tx, 1'b1);
        rx_q.push_back(b);
      end
    end
  end

  logic [7:0] exp1 [NB] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
  logic [7:0] exp2 [NB] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp3 [NB] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD};

  int base_rx, b_done, b_drop, b_busy;

  task automatic mark();
    base_rx = rx_q.size();
    b_done  = done_cnt;
    b_drop  = drop_cnt;
    b_busy  = busy_cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
    repeat (60) @(negedge Clk);
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp [NB]);
    check({name, "_byte_count"}, rx_q.size() - base_rx, NB);
    for (int i = 0; i < NB; i++)
      if (base_rx + i < rx_q.size()) check({name, "_byte"}, rx_q[base_rx + i], exp[i]);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge Clk);
    trig = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; trig = 1'b0; period_en = 1'b0; ch_data = '0;
    @(negedge Clk);
    #1;
    check("rst_tx", Rs232_Tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_dropped", dropped, 1'b0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Known frame; inputs change mid-frame without effect.
    ch_data = {32'h9ABCDEF0, 32'h12345678};
    mark();
    pulse_trig();
    repeat (19) @(negedge Clk);
    ch_data = '0;
    wait_idle(2 * L);
    check_frame("s1", exp1);
    check("s1_busy_cycles", busy_cyc - b_busy, 400);
    check("s1_done_pulses", done_cnt - b_done, 1);
    check("s1_dropped", drop_cnt - b_drop, 0);

    // Zero payload.
    mark();
    pulse_trig();
    wait_idle(2 * L);
    check_frame("s2", exp2);

    // trig held for 5 cycles from idle.
    ch_data = {$urandom, $urandom};
    mark();
    trig = 1'b1;
    repeat (5) @(negedge Clk);
    trig = 1'b0;
    wait_idle(2 * L);
    check("s3_done_pulses", done_cnt - b_done, 1);
    check("s3_dropped", drop_cnt - b_drop, 4);

    // Periodic: ticks at 300 and 900 start frames, 600 lands inside the first frame.
    mark();
    period_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ch_data = {$urandom, $urandom};
      @(negedge Clk);
    end
    period_en = 1'b0;
    wait_idle(2 * L);
    check("s4_done_pulses", done_cnt - b_done, 2);
    check("s4_dropped", drop_cnt - b_drop, 1);
    check("s4_bytes", rx_q.size() - base_rx, 2 * NB);

    // trig coincident with tick counts as one request.
    mark();
    period_en = 1'b1;
    repeat (PERIOD - 1) @(negedge Clk);
    trig = 1'b1;
    @(negedge Clk);
    trig = 1'b0;
    period_en = 1'b0;
    check("s5_busy_after_tick", busy, 1'b1);
    wait_idle(2 * L);
    check("s5_done_pulses", done_cnt - b_done, 1);
    check("s5_dropped", drop_cnt - b_drop, 0);

    // Random mix of triggers, periodic enable and changing data.
    for (int i = 0; i < 3000; i++) begin
      ch_data = {$urandom, $urandom};
      trig    = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 399) == 0) period_en = ~period_en;
      @(negedge Clk);
    end
    trig = 1'b0;
    period_en = 1'b0;
    wait_idle(2 * L);

    // Reset in the middle of a byte.
    ch_data = {$urandom, $urandom};
    pulse_trig();
    repeat (149) @(negedge Clk);
    mark();
    #1;
    Rst_n = 1'b0;
    #1;
    check("s7_async_tx", Rs232_Tx, 1'b1);
    check("s7_async_busy", busy, 1'b0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (60) @(negedge Clk);
    check("s7_no_done", done_cnt - b_done, 0);
    ch_data = {32'hFFFFFFFF, 32'h00000001};
    mark();
    pulse_trig();
    wait_idle(2 * L);
    check_frame("s7", exp3);
    check("s7_done_pulses", done_cnt - b_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
